// File: rtl/player_pkg.sv
// Shared types for the frame player and its helpers.
//   player_state_t : playback FSM states
//   cx_sample_t    : default complex sample {im, re} at 16 bits per component
//   frame_last()   : true when an address is the last sample of its frame
package player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } player_state_t;

  localparam int DEF_WIDTH = 16;

  typedef logic [2*DEF_WIDTH-1:0] cx_sample_t;

  function automatic logic frame_last(input int unsigned addr, input int unsigned frame_len);
    return (addr % frame_len) == (frame_len - 32'd1);
  endfunction

endpackage

// File: rtl/axis_frame_player_chk.sv
// Simulation checks for the frame player output stream.
//   clk, rst              : clock and synchronous reset
//   tvalid/tready/tdata/tlast : observed AXI-Stream master signals
// Confirms the frame geometry and that a stalled beat is held unchanged.
module axis_frame_player_chk #(
  parameter int DW        = 32,
  parameter int DEPTH     = 64,
  parameter int FRAME_LEN = 64
) (
  input logic          clk,
  input logic          rst,
  input logic          tvalid,
  input logic          tready,
  input logic [DW-1:0] tdata,
  input logic          tlast
);

  logic          stall_q;
  logic [DW-1:0] data_q;
  logic          last_q;

  // Remember whether the previous cycle ended in a stall (reset excuses it).
  always_ff @(posedge clk) begin
    stall_q <= tvalid && !tready && !rst;
    data_q  <= tdata;
    last_q  <= tlast;
  end

  // After a stall the same beat must still be offered.
  always @(posedge clk) begin
    if (stall_q) begin
      assert (tvalid);
      assert (tdata == data_q);
      assert (tlast == last_q);
    end
    assert (DEPTH % FRAME_LEN == 0);
  end

endmodule

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port.
//   clk   : clock
//   we    : write strobe, waddr/wdata : write address/data
//   re    : read strobe, raddr : read address
//   rdata : read data, valid the cycle after re; holds when re is low
// Contents are never reset.
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_frame_player.sv
// Preloadable AXI-Stream playback source.
//   clk, rst             : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: RAM preload port, honoured only while idle
//   start                : pulse that begins playback (ignored while busy)
//   loop                 : sampled at start; wrap to address 0 after DEPTH-1
//   stop                 : pulse; playback ends at the next frame boundary
//   m_axis_tdata/tvalid/tready/tlast : output stream, tdata = {im, re}
//   busy                 : high from the accepted start until done
//   done                 : one-cycle pulse after the final tlast handshake
//   frame_cnt            : frames completed since the last start
module axis_frame_player
  import player_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int FRAME_LEN = 64,
  parameter int CNT_WID   = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic                 start,
  input  logic                 loop,
  input  logic                 stop,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WID-1:0]   frame_cnt
);

  localparam int DW = 2*WIDTH;

  player_state_t state;
  logic [AW-1:0] rd_ptr;
  logic          loop_q;
  logic          stop_req;
  logic          rd_vld;     // RAM output register holds an unbuffered sample
  logic          rd_last;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] buf_data [2];
  logic          buf_last [2];
  logic          buf_rd;
  logic          buf_wr;
  logic [1:0]    buf_cnt;
  logic [1:0]    occ;
  logic          issue;
  logic          addr_last;
  logic          final_rd;
  logic          pop;
  logic          push;
  logic          drop;
  logic          drain_done;
  logic          ram_we;

  sdp_ram #(.WIDTH(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Read issue, stream head selection and buffer bookkeeping.
  always_comb begin
    // Samples at the RAM output count as occupancy so the 2-entry buffer never overflows.
    occ       = buf_cnt + {1'b0, rd_vld};
    issue     = (state == RUN) && (occ < 2'd2);
    addr_last = frame_last(32'(rd_ptr), FRAME_LEN);
    final_rd  = issue && (((rd_ptr == AW'(DEPTH-1)) && !loop_q) ||
                          (addr_last && (stop_req || stop)));
    m_axis_tvalid = (buf_cnt != 2'd0) || rd_vld;
    // With an empty buffer the RAM output is presented directly; it is pushed
    // into the buffer if not taken, so the head stays put under a stall.
    if (buf_cnt != 2'd0) begin
      m_axis_tdata = buf_data[buf_rd];
      m_axis_tlast = buf_last[buf_rd];
    end else begin
      m_axis_tdata = ram_rdata;
      m_axis_tlast = rd_last;
    end
    pop        = m_axis_tvalid && m_axis_tready;
    drop       = pop && (buf_cnt != 2'd0);
    push       = rd_vld && !(pop && (buf_cnt == 2'd0));
    drain_done = (state == DRAIN) && (occ == {1'b0, pop});
    ram_we     = wr_en && (state == IDLE);
  end

  // Playback FSM with status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      rd_ptr    <= '0;
      loop_q    <= 1'b0;
      stop_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop && m_axis_tlast) begin
        frame_cnt <= frame_cnt + CNT_WID'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            loop_q    <= loop;
            stop_req  <= 1'b0;
            frame_cnt <= '0;
            rd_ptr    <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            stop_req <= 1'b1;
          end
          if (issue) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            if (final_rd) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM output stage and 2-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      buf_cnt <= 2'd0;
      buf_rd  <= 1'b0;
      buf_wr  <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_last <= addr_last;
      end
      if (push) begin
        buf_data[buf_wr] <= ram_rdata;
        buf_last[buf_wr] <= rd_last;
        buf_wr           <= ~buf_wr;
      end
      if (drop) begin
        buf_rd <= ~buf_rd;
      end
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, drop};
    end
  end

  axis_frame_player_chk #(.DW(DW), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .tvalid (m_axis_tvalid),
    .tready (m_axis_tready),
    .tdata  (m_axis_tdata),
    .tlast  (m_axis_tlast)
  );

endmodule
